// File: rtl/retire_trace_buffer.sv
// Retirement trace sink: captures committed register writes and stores into a
// first-word-fall-through FIFO and streams them to a host link; overflow drops, never stalls.
module retire_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int PC_WIDTH  = 32,
  parameter int SEQ_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 wbValid,
  input  logic                 wbIsLoad,
  input  logic [PC_WIDTH-1:0]  wbPc,
  input  logic [4:0]           wbRdAddr,
  input  logic [31:0]          wbData,
  input  logic [31:0]          wbMemAddr,
  input  logic                 stValid,
  input  logic [PC_WIDTH-1:0]  stPc,
  input  logic [31:0]          stAddr,
  input  logic [31:0]          stData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [1:0]           outKind,
  output logic [PC_WIDTH-1:0]  outPc,
  output logic [4:0]           outRd,
  output logic [31:0]          outAddr,
  output logic [31:0]          outData,
  output logic [SEQ_WIDTH-1:0] outSeq,
  output logic [SEQ_WIDTH-1:0] dropCount,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [SEQ_WIDTH-1:0] DROP_MAX = '1;

  logic [1:0]           kind_mem [DEPTH];
  logic [PC_WIDTH-1:0]  pc_mem   [DEPTH];
  logic [4:0]           rd_mem   [DEPTH];
  logic [31:0]          addr_mem [DEPTH];
  logic [31:0]          data_mem [DEPTH];
  logic [SEQ_WIDTH-1:0] seq_mem  [DEPTH];

  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [AW:0]          count;
  logic [SEQ_WIDTH-1:0] seq;

  logic                 ev_wb, ev_st, push_wb, push_st, pop;
  logic [AW:0]          free_slots, count_next;
  logic [1:0]           n_push, n_drop;
  logic [AW-1:0]        st_slot;
  logic [SEQ_WIDTH-1:0] st_seq, drop_next;
  logic [SEQ_WIDTH:0]   drop_sum;
  logic [1:0]           wb_kind;
  logic [31:0]          wb_addr;

  // Free slots use the pre-edge count, so a same-cycle pop never makes room for a push.
  always_comb begin
    ev_wb      = enable & wbValid;
    ev_st      = enable & stValid;
    free_slots = DEPTH_C - count;
    push_wb    = ev_wb && (free_slots != '0);
    push_st    = ev_st && (free_slots > (AW+1)'(push_wb));
    n_push     = {1'b0, push_wb} + {1'b0, push_st};
    n_drop     = {1'b0, ev_wb & ~push_wb} + {1'b0, ev_st & ~push_st};
    pop        = outValid & outReady;
    st_slot    = wr_ptr + AW'(push_wb);
    st_seq     = seq + SEQ_WIDTH'(ev_wb);
    wb_kind    = wbIsLoad ? 2'b10 : 2'b01;
    wb_addr    = wbIsLoad ? wbMemAddr : 32'h0;
    drop_sum   = {1'b0, dropCount} + (SEQ_WIDTH+1)'(n_drop);
    drop_next  = drop_sum[SEQ_WIDTH] ? DROP_MAX : drop_sum[SEQ_WIDTH-1:0];
    count_next = count + (AW+1)'(n_push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      seq       <= '0;
      dropCount <= '0;
    end else begin
      rd_ptr    <= rd_ptr + AW'(pop);
      wr_ptr    <= wr_ptr + AW'(n_push);
      count     <= count_next;
      seq       <= seq + SEQ_WIDTH'(n_drop + n_push);
      dropCount <= drop_next;
    end
  end

  // Storage is not reset; the reset cycle simply suppresses writes.
  always_ff @(posedge clk) begin
    if (rst && push_wb) begin
      kind_mem[wr_ptr] <= wb_kind;
      pc_mem[wr_ptr]   <= wbPc;
      rd_mem[wr_ptr]   <= wbRdAddr;
      addr_mem[wr_ptr] <= wb_addr;
      data_mem[wr_ptr] <= wbData;
      seq_mem[wr_ptr]  <= seq;
    end
    if (rst && push_st) begin
      kind_mem[st_slot] <= 2'b11;
      pc_mem[st_slot]   <= stPc;
      rd_mem[st_slot]   <= 5'd0;
      addr_mem[st_slot] <= stAddr;
      data_mem[st_slot] <= stData;
      seq_mem[st_slot]  <= st_seq;
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign outValid = !empty;
  assign outKind  = kind_mem[rd_ptr];
  assign outPc    = pc_mem[rd_ptr];
  assign outRd    = rd_mem[rd_ptr];
  assign outAddr  = addr_mem[rd_ptr];
  assign outData  = data_mem[rd_ptr];
  assign outSeq   = seq_mem[rd_ptr];

endmodule
